// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-back arbiter bus: load/ALU sources, register file port, hazard query
interface rf_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BUF_DEPTH  = 2
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  ld_valid_i;
  logic [ADDR_WIDTH-1:0] ld_rd_i;
  logic [DATA_WIDTH-1:0] ld_data_i;
  logic                  alu_valid_i;
  logic [ADDR_WIDTH-1:0] alu_rd_i;
  logic [DATA_WIDTH-1:0] alu_data_i;
  logic                  alu_ready_o;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_rd_o;
  logic [DATA_WIDTH-1:0] rf_data_o;
  logic [ADDR_WIDTH-1:0] rs1_addr_i;
  logic [ADDR_WIDTH-1:0] rs2_addr_i;
  logic                  rs1_pend_o;
  logic                  rs2_pend_o;
  logic                  busy_o;
  logic [CNT_W-1:0]      count_o;

  modport master (
    output ld_valid_i, ld_rd_i, ld_data_i,
    output alu_valid_i, alu_rd_i, alu_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  alu_ready_o, rf_we_o, rf_rd_o, rf_data_o,
    input  rs1_pend_o, rs2_pend_o, busy_o, count_o
  );

  modport slave (
    input  ld_valid_i, ld_rd_i, ld_data_i,
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output alu_ready_o, rf_we_o, rf_rd_o, rf_data_o,
    output rs1_pend_o, rs2_pend_o, busy_o, count_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - merges load and ALU write-backs onto one register file write port in program order
// Parameters must match those of the connected rf_wb_arbiter_if instance.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BUF_DEPTH  = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rf_wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;

  logic [ADDR_WIDTH-1:0] buf_rd_q   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  occ_q, occ_d;
  ptr_t                  rptr_q, rptr_d, wptr_q, wptr_d, wptr_b;
  logic [CW-1:0]         count_q, count_d;

  logic                  ldw, aluw, head_v, issue;
  logic                  push_a, push_b;
  logic [ADDR_WIDTH-1:0] a_rd, b_rd;
  logic [DATA_WIDTH-1:0] a_data, b_data;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(BUF_DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  assign head_v = (count_q != '0);
  assign ldw    = bus.ld_valid_i && (bus.ld_rd_i != '0);

  // Reserving room for a possible load keeps loads unstallable and the buffer bounded.
  assign bus.alu_ready_o = ({1'b0, count_q} + {{CW{1'b0}}, ldw}) <= (CW + 1)'(BUF_DEPTH);
  assign aluw  = bus.alu_valid_i && (bus.alu_rd_i != '0) && bus.alu_ready_o;
  assign issue = head_v || ldw || aluw;

  assign bus.rf_we_o = issue && rst_ni;
  assign bus.busy_o  = head_v;
  assign bus.count_o = count_q;

  always_comb begin
    bus.rf_rd_o   = buf_rd_q[rptr_q];
    bus.rf_data_o = buf_data_q[rptr_q];
    if (!head_v) begin
      if (ldw) begin
        bus.rf_rd_o   = bus.ld_rd_i;
        bus.rf_data_o = bus.ld_data_i;
      end else begin
        bus.rf_rd_o   = bus.alu_rd_i;
        bus.rf_data_o = bus.alu_data_i;
      end
    end
  end

  // Everything accepted except the single issuing write goes to the tail, load first.
  always_comb begin
    push_a = 1'b0;
    push_b = 1'b0;
    a_rd   = bus.ld_rd_i;
    a_data = bus.ld_data_i;
    b_rd   = bus.alu_rd_i;
    b_data = bus.alu_data_i;
    if (head_v) begin
      if (ldw) begin
        push_a = 1'b1;
        push_b = aluw;
      end else if (aluw) begin
        push_a = 1'b1;
        a_rd   = bus.alu_rd_i;
        a_data = bus.alu_data_i;
      end
    end else if (ldw && aluw) begin
      push_a = 1'b1;
      a_rd   = bus.alu_rd_i;
      a_data = bus.alu_data_i;
    end
  end

  assign wptr_b = ptr_inc(wptr_q);

  always_comb begin
    occ_d = occ_q;
    if (head_v) occ_d[rptr_q] = 1'b0;
    if (push_a) occ_d[wptr_q] = 1'b1;
    if (push_b) occ_d[wptr_b] = 1'b1;
    rptr_d = head_v ? ptr_inc(rptr_q) : rptr_q;
    if (push_b)      wptr_d = ptr_inc(wptr_b);
    else if (push_a) wptr_d = wptr_b;
    else             wptr_d = wptr_q;
    count_d = count_q + CW'(ldw) + CW'(aluw) - CW'(issue);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: occupancy and count alone decide what is live.
  always_ff @(posedge clk_i) begin
    if (push_a) begin
      buf_rd_q[wptr_q]   <= a_rd;
      buf_data_q[wptr_q] <= a_data;
    end
    if (push_b) begin
      buf_rd_q[wptr_b]   <= b_rd;
      buf_data_q[wptr_b] <= b_data;
    end
  end

  always_comb begin
    bus.rs1_pend_o = 1'b0;
    bus.rs2_pend_o = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (occ_q[i] && (buf_rd_q[i] == bus.rs1_addr_i) && (bus.rs1_addr_i != '0)) bus.rs1_pend_o = 1'b1;
      if (occ_q[i] && (buf_rd_q[i] == bus.rs2_addr_i) && (bus.rs2_addr_i != '0)) bus.rs2_pend_o = 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized and directed bench for rf_wb_arbiter against a queue-based order model
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 2;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(D)) bus ();
  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(D)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  wr_t mq[$];
  logic [DW-1:0] tb_rf [32];

  logic          obs_we, obs_ready, obs_pend1;
  logic [AW-1:0] obs_rd;
  logic [DW-1:0] obs_data;
  int            obs_count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.ld_valid_i  = 1'b0;
    bus.ld_rd_i     = '0;
    bus.ld_data_i   = '0;
    bus.alu_valid_i = 1'b0;
    bus.alu_rd_i    = '0;
    bus.alu_data_i  = '0;
    bus.rs1_addr_i  = '0;
    bus.rs2_addr_i  = '0;
  endtask

  // One cycle: drive, check against the order model at negedge, advance model.
  task automatic step(input bit lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld,
                      input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, output bit acc);
    wr_t ord[$];
    bit  ldw, rdy, p1, p2;
    bus.ld_valid_i  = lv;
    bus.ld_rd_i     = lr;
    bus.ld_data_i   = ld;
    bus.alu_valid_i = av;
    bus.alu_rd_i    = ar;
    bus.alu_data_i  = ad;
    bus.rs1_addr_i  = rs1;
    bus.rs2_addr_i  = rs2;
    @(negedge clk);
    ord = mq;
    ldw = lv && (lr != 0);
    rdy = (mq.size() + int'(ldw)) <= D;
    if (ldw) ord.push_back('{rd: lr, data: ld});
    if (av && rdy && (ar != 0)) ord.push_back('{rd: ar, data: ad});
    p1 = 1'b0;
    p2 = 1'b0;
    foreach (mq[i]) begin
      if (rs1 != 0 && mq[i].rd == rs1) p1 = 1'b1;
      if (rs2 != 0 && mq[i].rd == rs2) p2 = 1'b1;
    end
    chk("alu_ready", bus.alu_ready_o, rdy);
    chk("busy", bus.busy_o, mq.size() != 0);
    chk("count", bus.count_o, mq.size());
    chk("rs1_pend", bus.rs1_pend_o, p1);
    chk("rs2_pend", bus.rs2_pend_o, p2);
    chk("rf_we", bus.rf_we_o, ord.size() != 0);
    if (ord.size() != 0) begin
      chk("rf_rd", bus.rf_rd_o, ord[0].rd);
      chk("rf_data", bus.rf_data_o, ord[0].data);
      void'(ord.pop_front());
    end
    obs_we    = bus.rf_we_o;
    obs_rd    = bus.rf_rd_o;
    obs_data  = bus.rf_data_o;
    obs_ready = bus.alu_ready_o;
    obs_pend1 = bus.rs1_pend_o;
    obs_count = int'(bus.count_o);
    if (obs_we) tb_rf[obs_rd] = obs_data;
    mq  = ord;
    acc = av && rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] rs1);
    bit acc;
    step(0, 0, 0, 0, 0, 0, rs1, 0, acc);
  endtask

  initial begin
    bit acc, hv, saw_stall;
    int maxcnt;
    logic [AW-1:0] ar;
    logic [DW-1:0] ad;
    bit lv, av;
    foreach (tb_rf[i]) tb_rf[i] = '0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", bus.rf_we_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_ready", bus.alu_ready_o, 1);
    chk("rst_pend", {bus.rs1_pend_o, bus.rs2_pend_o}, 0);
    rst_n = 1'b1;

    // Single ALU write, no load
    step(0, 0, 0, 1, 5, 32'h11, 0, 0, acc);
    chk("t1_we", obs_we, 1);
    chk("t1_rd", obs_rd, 5);
    chk("t1_data", obs_data, 32'h11);
    idle(0);
    chk("t1_count", obs_count, 0);

    // Load + ALU collision on empty buffer
    step(1, 3, 32'hAA, 1, 4, 32'hBB, 4, 0, acc);
    chk("t2_c0_rd", obs_rd, 3);
    chk("t2_c0_data", obs_data, 32'hAA);
    chk("t2_c0_pend", obs_pend1, 0);
    idle(4);
    chk("t2_c1_count", obs_count, 1);
    chk("t2_c1_rd", obs_rd, 4);
    chk("t2_c1_data", obs_data, 32'hBB);
    chk("t2_c1_pend", obs_pend1, 1);
    idle(4);
    chk("t2_c2_count", obs_count, 0);
    chk("t2_c2_pend", obs_pend1, 0);

    // Sustained collisions, ALU held while not ready
    hv = 0; saw_stall = 0; maxcnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (!hv) begin ar = AW'(10 + k); ad = 32'h100 + k; end
      step(1, AW'(16 + k), 32'h200 + k, 1, ar, ad, ar, 0, acc);
      if (obs_count > maxcnt) maxcnt = obs_count;
      if (!obs_ready) saw_stall = 1;
      hv = !acc;
    end
    chk("t3_maxcnt", maxcnt, D);
    chk("t3_stall", saw_stall, 1);
    for (int k = 0; k < 8 && hv; k++) begin
      step(0, 0, 0, 1, ar, ad, 0, 0, acc);
      hv = !acc;
    end
    chk("t3_alu_drained", hv, 0);
    repeat (D + 1) idle(0);
    chk("t3_empty", bus.count_o, 0);

    // x0 handling
    step(1, 0, 32'hDEAD, 1, 7, 32'h77, 0, 0, acc);
    chk("t4_rd", obs_rd, 7);
    chk("t4_data", obs_data, 32'h77);
    idle(0);
    chk("t4_count", obs_count, 0);
    step(0, 0, 0, 1, 0, 32'h55, 0, 0, acc);
    chk("t4_x0_we", obs_we, 0);

    // Same-rd ordering
    step(1, 9, 32'h1, 1, 9, 32'h2, 0, 0, acc);
    chk("t5_first", obs_data, 32'h1);
    idle(0);
    chk("t5_second", obs_data, 32'h2);
    chk("t5_final", tb_rf[9], 32'h2);

    // Reset with a full buffer
    step(1, 1, 32'h31, 1, 2, 32'h32, 0, 0, acc);
    step(1, 3, 32'h33, 1, 4, 32'h34, 0, 0, acc);
    chk("t6_full", bus.count_o, D);
    rst_n = 1'b0;
    bus.ld_valid_i  = 1'b1;
    bus.ld_rd_i     = 6;
    bus.alu_valid_i = 1'b0;
    bus.rs1_addr_i  = 3;
    #2;
    chk("t6_we", bus.rf_we_o, 0);
    chk("t6_busy", bus.busy_o, 0);
    chk("t6_count", bus.count_o, 0);
    chk("t6_pend", bus.rs1_pend_o, 0);
    bus.ld_valid_i = 1'b0;
    #1;
    chk("t6_ready", bus.alu_ready_o, 1);
    mq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) idle(3);

    // Random traffic with ALU hold protocol
    hv = 0;
    for (int i = 0; i < 500; i++) begin
      lv = $urandom_range(0, 1) == 1;
      if (!hv) begin
        av = $urandom_range(0, 2) != 0;
        ar = AW'($urandom_range(0, 7));
        ad = $urandom;
      end
      step(lv, AW'($urandom_range(0, 7)), $urandom, av, ar, ad,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), acc);
      hv = av && !acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
